// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the ALU, its sequencer and control unit.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEGIN = 3'd1,
    ST_OPA   = 3'd2,
    ST_OPB   = 3'd3,
    ST_HI2   = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // MUL and DIV return two bytes from the ALU; ADD and SUB return one.
  function automatic logic is_two_byte(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Down-counting wait timer: clear loads TIMEOUT_CYCLES-1, tc flags the last allowed cycle.
module alu_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = CW'(TIMEOUT_CYCLES - 1);
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command through a byte-serial ALU handshake and returns a 16-bit response.
//
// state    | meaning
// ST_IDLE  | ready for a command
// ST_BEGIN | alu_begin with opcode, bus zero
// ST_OPA   | alu_begin with operand A
// ST_OPB   | operand B held, waiting for alu_end or timeout
// ST_HI2   | capture second result byte (MUL/DIV)
// ST_RESP  | response held until rsp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d, byte0_q, byte0_d;
  logic        cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic        alu_begin_q, alu_begin_d;
  logic [1:0]  alu_op_code_q, alu_op_code_d;
  logic [7:0]  alu_inbus_q, alu_inbus_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        timer_tc;

  alu_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_OPA),
    .enable (state_q == ST_OPB),
    .tc     (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    byte0_d       = byte0_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = op_e'(cmd_op);
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = ST_BEGIN;
        end
      end
      ST_BEGIN: state_d = ST_OPA;
      ST_OPA:   state_d = ST_OPB;
      ST_OPB: begin
        // alu_end wins over a timer expiring in the same cycle.
        if (alu_end) begin
          byte0_d = alu_outbus;
          if (is_two_byte(op_q)) begin
            state_d = ST_HI2;
          end else begin
            rsp_data_d    = {8'h00, alu_outbus};
            rsp_timeout_d = 1'b0;
            state_d       = ST_RESP;
          end
        end else if (timer_tc) begin
          rsp_data_d    = 16'h0000;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_HI2: begin
        rsp_data_d    = {byte0_q, alu_outbus};
        rsp_timeout_d = 1'b0;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_data_d    = 16'h0000;
          rsp_timeout_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    alu_begin_d   = (state_d == ST_BEGIN) || (state_d == ST_OPA);
    rsp_valid_d   = (state_d == ST_RESP);
    alu_op_code_d = 2'b00;
    alu_inbus_d   = 8'h00;
    case (state_d)
      ST_BEGIN: alu_op_code_d = op_d;
      ST_OPA: begin
        alu_op_code_d = op_d;
        alu_inbus_d   = a_d;
      end
      ST_OPB, ST_HI2: begin
        alu_op_code_d = op_d;
        alu_inbus_d   = b_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      a_q           <= 8'h00;
      b_q           <= 8'h00;
      byte0_q       <= 8'h00;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      alu_begin_q   <= 1'b0;
      alu_op_code_q <= 2'b00;
      alu_inbus_q   <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 16'h0000;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      byte0_q       <= byte0_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      alu_begin_q   <= alu_begin_d;
      alu_op_code_q <= alu_op_code_d;
      alu_inbus_q   <= alu_inbus_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign alu_begin   = alu_begin_q;
  assign alu_op_code = alu_op_code_q;
  assign alu_inbus   = alu_inbus_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a cycle-driven byte-serial ALU model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus, alu_outbus;
  logic        alu_end;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [15:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_begin   (alu_begin),
    .alu_op_code (alu_op_code),
    .alu_inbus   (alu_inbus),
    .alu_outbus  (alu_outbus),
    .alu_end     (alu_end),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU model: first byte with alu_end, second byte on the following cycle.
  function automatic logic [15:0] alu_bytes(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [7:0]  s;
    case (op)
      2'b00: begin s = a + b; return {s, 8'h00}; end
      2'b01: begin s = a - b; return {s, 8'h00}; end
      2'b10: begin p = a * b; return p; end
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic logic [16:0] exp_rsp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    logic [7:0]  s;
    case (op)
      2'b00: begin s = a + b; return {1'b0, 8'h00, s}; end
      2'b01: begin s = a - b; return {1'b0, 8'h00, s}; end
      2'b10: begin prod = a * b; return {1'b0, prod}; end
      default: return {1'b0, a % b, a / b};
    endcase
  endfunction

  task automatic get_rsp(input int hold);
    logic [16:0] exp;
    int waited;
    waited = 0;
    while (!rsp_valid && waited < TO + 20) begin
      @(negedge clk);
      waited++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1FFFF;
    check("rsp_payload", 32'({rsp_timeout, rsp_data}), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", 32'({rsp_valid, rsp_timeout, rsp_data, cmd_ready, busy}),
            32'({1'b1, exp, 1'b0, 1'b1}));
    end
    check("ready_low_in_handshake", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_handshake", 32'({rsp_valid, cmd_ready, busy, rsp_data}), 32'({3'b010, 16'h0000}));
  endtask

  // mode: 0 normal, 1 ALU never answers, 2 reset pulsed during OPB
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int delay, input int hold, input logic [16:0] exp,
                        input bit early_end, input int mode);
    logic [15:0] bytes;
    int waited;
    bytes  = alu_bytes(op, a, b);
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (early_end) begin
      alu_end    = 1'b1;
      alu_outbus = 8'hEE;
    end
    check("begin_cycle", 32'({alu_begin, alu_op_code, alu_inbus, busy, cmd_ready}),
          32'({1'b1, op, 8'h00, 1'b1, 1'b0}));
    @(negedge clk);
    check("opa_cycle", 32'({alu_begin, alu_op_code, alu_inbus}), 32'({1'b1, op, a}));
    @(negedge clk);
    alu_end = 1'b0;
    check("opb_entry", 32'({alu_begin, alu_op_code, alu_inbus, rsp_valid}), 32'({1'b0, op, b, 1'b0}));
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_reset_values",
            32'({cmd_ready, busy, alu_begin, alu_op_code, alu_inbus, rsp_valid, rsp_data, rsp_timeout}),
            32'({1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 16'h0000, 1'b0}));
      void'(exp_q.pop_back());
      return;
    end
    if (mode == 1) begin
      alu_outbus = 8'h5A;
      waited = 0;
      while (!rsp_valid && waited < TO + 10) begin
        @(negedge clk);
        waited++;
      end
      check("timeout_len", 32'(waited), 32'(TO));
    end else begin
      repeat (delay) @(negedge clk);
      alu_end    = 1'b1;
      alu_outbus = bytes[15:8];
      @(negedge clk);
      alu_end    = 1'b0;
      alu_outbus = bytes[7:0];
      if (op[1]) begin
        check("hi2_cycle", 32'({rsp_valid, alu_op_code, busy}), 32'({1'b0, op, 1'b1}));
        @(negedge clk);
        alu_outbus = 8'h00;
      end
      check("rsp_latency", 32'(rsp_valid), 32'd1);
    end
    get_rsp(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r_op;
    logic [7:0] r_a, r_b;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_a      = 8'h00;
    cmd_b      = 8'h00;
    alu_outbus = 8'h00;
    alu_end    = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",
          32'({cmd_ready, busy, alu_begin, alu_op_code, alu_inbus, rsp_valid, rsp_data, rsp_timeout}),
          32'({1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 16'h0000, 1'b0}));
    reset = 1'b0;

    alu_end    = 1'b1;
    alu_outbus = 8'h77;
    repeat (2) @(negedge clk);
    check("idle_ignores_end", 32'({cmd_ready, busy, rsp_valid}), 32'({1'b1, 1'b0, 1'b0}));
    alu_end = 1'b0;

    run_op(2'b00, 8'd56,  8'd89, 0, 0,  {1'b0, 16'h0091}, 1'b0, 0);
    run_op(2'b01, 8'd56,  8'd89, 2, 0,  {1'b0, 16'h00DF}, 1'b0, 0);
    run_op(2'b10, 8'd56,  8'd89, 1, 10, {1'b0, 16'h1378}, 1'b0, 0);
    run_op(2'b11, 8'd200, 8'd7,  3, 0,  {1'b0, 16'h041C}, 1'b1, 0);
    run_op(2'b00, 8'd5,   8'd5,  0, 2,  {1'b1, 16'h0000}, 1'b0, 1);
    run_op(2'b00, 8'd250, 8'd10, TO - 1, 0, {1'b0, 16'h0004}, 1'b0, 0);
    run_op(2'b10, 8'd255, 8'd255, TO - 1, 0, {1'b0, 16'hFE01}, 1'b0, 0);
    run_op(2'b10, 8'd56,  8'd89, 0, 0,  {1'b0, 16'h1378}, 1'b0, 2);
    run_op(2'b00, 8'd1,   8'd2,  0, 0,  {1'b0, 16'h0003}, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = 8'($urandom_range(0, 255));
      r_b  = 8'($urandom_range(1, 255));
      run_op(r_op, r_a, r_b, $urandom_range(0, 5), $urandom_range(0, 3),
             exp_rsp(r_op, r_a, r_b), 1'b0, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
